sha256_round_ctrl: RTL and testbench

// Sequencer for the SHA-256 compression datapath. Accepts 512-bit blocks over a valid/ready handshake.

---
 rtl/sha256_pkg.sv | 42 ++++
 rtl/sha256_k_rom.sv | 18 +
 rtl/sha256_round_ctrl.sv | 158 +++++++++++++++
 tb/tb_sha256_round_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: controller state encoding, round constants K and initial hash H0..H7.
package sha256_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRound,
        StAdd,
        StDone
    } ctrl_state_t;

    localparam int unsigned KNum = 64;

    localparam logic [31:0] K [KNum] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] H0 = 32'h6a09e667;
    localparam logic [31:0] H1 = 32'hbb67ae85;
    localparam logic [31:0] H2 = 32'h3c6ef372;
    localparam logic [31:0] H3 = 32'ha54ff53a;
    localparam logic [31:0] H4 = 32'h510e527f;
    localparam logic [31:0] H5 = 32'h9b05688c;
    localparam logic [31:0] H6 = 32'h1f83d9ab;
    localparam logic [31:0] H7 = 32'h5be0cd19;

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational lookup of the SHA-256 round constant K[idx].
module sha256_k_rom
    import sha256_pkg::*;
#(
    parameter int unsigned IdxW = 6
) (
    input  logic [IdxW-1:0] idx_i,
    output logic [31:0]     kt_o
);

    logic [5:0] idx6;

    always_comb begin
        idx6 = 6'(idx_i);
        kt_o = K[idx6];
    end

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: block handshake, load/round/final-add control, digest-valid hold.
// Optional block counter output enabled by defining SHA256_CTRL_BLKCNT_EN.
module sha256_round_ctrl
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS = 64,
`ifdef SHA256_CTRL_BLKCNT_EN
    parameter int unsigned BLKCNT_W = 16,
`endif
    localparam int unsigned RND_W = $clog2(ROUNDS)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               req_valid_i,
    input  logic               req_last_i,
    output logic               req_ready_o,
    output logic               init_hash_o,
    output logic               load_block_o,
    output logic               round_en_o,
    output logic [RND_W-1:0]   round_idx_o,
    output logic [31:0]        kt_o,
    output logic               final_add_o,
    output logic               hash_valid_o,
    input  logic               hash_ack_i,
`ifdef SHA256_CTRL_BLKCNT_EN
    output logic [BLKCNT_W-1:0] blk_count_o,
`endif
    output logic               busy_o
);

    localparam logic [RND_W-1:0] RndLast = RND_W'(ROUNDS - 1);

    ctrl_state_t      state_q, state_d;
    logic [RND_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             first_blk_q, first_blk_d;
    logic [31:0]      rom_kt;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            first_blk_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            first_blk_q <= first_blk_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        first_blk_d = first_blk_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    last_d  = req_last_i;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                first_blk_d = 1'b0;
                cnt_d       = '0;
                state_d     = StRound;
            end
            StRound: begin
                // Hold at the last index rather than wrapping; ADD follows immediately.
                if (cnt_q == RndLast) begin
                    state_d = StAdd;
                end else begin
                    cnt_d = cnt_q + RND_W'(1);
                end
            end
            StAdd: begin
                if (last_q) begin
                    first_blk_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                if (hash_ack_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready_o  = 1'b0;
        init_hash_o  = 1'b0;
        load_block_o = 1'b0;
        round_en_o   = 1'b0;
        round_idx_o  = '0;
        final_add_o  = 1'b0;
        hash_valid_o = 1'b0;
        busy_o       = 1'b0;
        unique case (state_q)
            StIdle:  req_ready_o = 1'b1;
            StLoad: begin
                load_block_o = 1'b1;
                init_hash_o  = first_blk_q;
                busy_o       = 1'b1;
            end
            StRound: begin
                round_en_o  = 1'b1;
                round_idx_o = cnt_q;
                busy_o      = 1'b1;
            end
            StAdd: begin
                final_add_o = 1'b1;
                busy_o      = 1'b1;
            end
            StDone:  hash_valid_o = 1'b1;
            default: ;
        endcase
    end

    sha256_k_rom #(
        .IdxW (RND_W)
    ) u_k_rom (
        .idx_i (round_idx_o),
        .kt_o  (rom_kt)
    );

    // K[0] is non-zero, so the constant must be gated outside ROUND.
    assign kt_o = round_en_o ? rom_kt : 32'h0;

`ifdef SHA256_CTRL_BLKCNT_EN
    logic [BLKCNT_W-1:0] blk_cnt_q, blk_cnt_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            blk_cnt_q <= '0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
        end
    end

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (state_q == StLoad && first_blk_q) begin
            blk_cnt_d = '0;
        end else if (state_q == StAdd && blk_cnt_q != '1) begin
            blk_cnt_d = blk_cnt_q + BLKCNT_W'(1);
        end
    end

    assign blk_count_o = blk_cnt_q;
`endif

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: behavioural SHA-256 core driven by the controller, digest scoreboard.
module tb_sha256_round_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_last, req_ready;
    logic        init_hash, load_block, round_en, final_add, hash_valid, hash_ack, busy;
    logic [5:0]  round_idx;
    logic [31:0] kt;
`ifdef SHA256_CTRL_BLKCNT_EN
    logic [15:0] blk_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [255:0] exp_q [$];

    always #5 clk = ~clk;

    sha256_round_ctrl dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .req_valid_i  (req_valid),
        .req_last_i   (req_last),
        .req_ready_o  (req_ready),
        .init_hash_o  (init_hash),
        .load_block_o (load_block),
        .round_en_o   (round_en),
        .round_idx_o  (round_idx),
        .kt_o         (kt),
        .final_add_o  (final_add),
        .hash_valid_o (hash_valid),
        .hash_ack_i   (hash_ack),
`ifdef SHA256_CTRL_BLKCNT_EN
        .blk_count_o  (blk_count),
`endif
        .busy_o       (busy)
    );

    // Reference core: follows the controller's strobes and uses its kt.
    logic [31:0] iv [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                            32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    logic [31:0] blk [16];
    logic [31:0] hh [8];
    logic [31:0] ra [8];
    logic [31:0] w [16];
    logic [31:0] t1, t2;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    always @(posedge clk) begin
        if (load_block) begin
            for (int i = 0; i < 8; i++) begin
                hh[i] <= init_hash ? iv[i] : hh[i];
                ra[i] <= init_hash ? iv[i] : hh[i];
            end
            for (int i = 0; i < 16; i++) w[i] <= blk[i];
        end else if (round_en) begin
            t1 = ra[7] + (rotr(ra[4], 6) ^ rotr(ra[4], 11) ^ rotr(ra[4], 25))
                 + ((ra[4] & ra[5]) ^ (~ra[4] & ra[6])) + kt + w[0];
            t2 = (rotr(ra[0], 2) ^ rotr(ra[0], 13) ^ rotr(ra[0], 22))
                 + ((ra[0] & ra[1]) ^ (ra[0] & ra[2]) ^ (ra[1] & ra[2]));
            ra[0] <= t1 + t2;
            ra[1] <= ra[0];
            ra[2] <= ra[1];
            ra[3] <= ra[2];
            ra[4] <= ra[3] + t1;
            ra[5] <= ra[4];
            ra[6] <= ra[5];
            ra[7] <= ra[6];
            for (int i = 0; i < 15; i++) w[i] <= w[i + 1];
            w[15] <= (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
                     + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
        end else if (final_add) begin
            for (int i = 0; i < 8; i++) hh[i] <= hh[i] + ra[i];
        end
    end

    logic [511:0] abc_blk, two_b1, two_b2;
    logic [255:0] abc_dig, two_dig;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic drive_block(input logic [511:0] data, input logic last, input logic exp_init,
                               input logic [255:0] dig);
        int waitc;
        @(negedge clk);
        for (int i = 0; i < 16; i++) blk[i] = data[511 - 32 * i -: 32];
        req_valid = 1'b1;
        req_last  = last;
        waitc = 0;
        while (req_ready !== 1'b1 && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_wait req_ready=%b want 1", req_ready);
        end
        if (last) exp_q.push_back(dig);
        @(negedge clk);
        req_valid = 1'b0;
        req_last  = 1'b0;
        checks++;
        if (load_block !== 1'b1 || init_hash !== exp_init || busy !== 1'b1 || req_ready !== 1'b0)
        begin
            errors++;
            $display("FAIL load load=%b init=%b busy=%b rdy=%b want 1 %b 1 0",
                     load_block, init_hash, busy, req_ready, exp_init);
        end
        for (int r = 0; r < 64; r++) begin
            @(negedge clk);
            checks++;
            if (round_en !== 1'b1 || round_idx !== 6'(r)) begin
                errors++;
                $display("FAIL round en=%b idx=%0d want 1 %0d", round_en, round_idx, r);
            end
            if (r == 0) begin
                checks++;
                if (kt !== 32'h428a2f98) begin
                    errors++;
                    $display("FAIL kt0 got %h want 428a2f98", kt);
                end
            end
            if (r == 63) begin
                checks++;
                if (kt !== 32'hc67178f2) begin
                    errors++;
                    $display("FAIL kt63 got %h want c67178f2", kt);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (final_add !== 1'b1 || round_en !== 1'b0 || round_idx !== 6'd0 || kt !== 32'h0
            || hash_valid !== 1'b0) begin
            errors++;
            $display("FAIL add fa=%b en=%b idx=%0d kt=%h hv=%b want 1 0 0 0 0",
                     final_add, round_en, round_idx, kt, hash_valid);
        end
        @(negedge clk);
        checks++;
        if (last) begin
            if (hash_valid !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL done_latency hv=%b busy=%b rdy=%b want 1 0 0",
                         hash_valid, busy, req_ready);
            end
        end else begin
            if (hash_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_idle hv=%b busy=%b rdy=%b want 0 0 1",
                         hash_valid, busy, req_ready);
            end
        end
    endtask

    task automatic check_digest();
        int waitc;
        logic [255:0] want;
        waitc = 0;
        while (hash_valid !== 1'b1 && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        checks++;
        if (hash_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL digest_wait hv=%b queued=%0d want 1 and >0", hash_valid, exp_q.size());
        end else begin
            want = exp_q.pop_front();
            if ({hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]} !== want) begin
                errors++;
                $display("FAIL digest got %h want %h",
                         {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]}, want);
            end
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        hash_ack = 1'b1;
        @(negedge clk);
        hash_ack = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || hash_valid !== 1'b0) begin
            errors++;
            $display("FAIL ack_idle rdy=%b hv=%b want 1 0", req_ready, hash_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({req_ready, init_hash, load_block, round_en, final_add, hash_valid, busy} !== 7'b1000000
            || round_idx !== 6'd0 || kt !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got %b idx=%0d kt=%h want 1000000 0 0",
                     {req_ready, init_hash, load_block, round_en, final_add, hash_valid, busy},
                     round_idx, kt);
        end
`ifdef SHA256_CTRL_BLKCNT_EN
        checks++;
        if (blk_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_blkcnt got %0d want 0", blk_count);
        end
`endif
    endtask

    task automatic test_abc();
        drive_block(abc_blk, 1'b1, 1'b1, abc_dig);
        check_digest();
        do_ack();
    endtask

    task automatic test_two_block();
        drive_block(two_b1, 1'b0, 1'b1, 256'h0);
        drive_block(two_b2, 1'b1, 1'b0, two_dig);
        check_digest();
`ifdef SHA256_CTRL_BLKCNT_EN
        checks++;
        if (blk_count !== 16'd2) begin
            errors++;
            $display("FAIL blkcnt_two got %0d want 2", blk_count);
        end
`endif
        do_ack();
    endtask

    task automatic test_backpressure();
        drive_block(abc_blk, 1'b1, 1'b1, abc_dig);
        check_digest();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_valid = i[0];
            req_last  = 1'b1;
            checks++;
            if (hash_valid !== 1'b1 || req_ready !== 1'b0 || load_block !== 1'b0) begin
                errors++;
                $display("FAIL hold hv=%b rdy=%b load=%b want 1 0 0",
                         hash_valid, req_ready, load_block);
            end
        end
`ifdef SHA256_CTRL_BLKCNT_EN
        checks++;
        if (blk_count !== 16'd1) begin
            errors++;
            $display("FAIL blkcnt_one got %0d want 1", blk_count);
        end
`endif
        @(negedge clk);
        req_valid = 1'b0;
        req_last  = 1'b0;
        hash_ack  = 1'b1;
        @(negedge clk);
        hash_ack = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || hash_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release rdy=%b hv=%b want 1 0", req_ready, hash_valid);
        end
        @(negedge clk);
        checks++;
        if (load_block !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_not_consumed load=%b rdy=%b want 0 1", load_block, req_ready);
        end
    endtask

    task automatic test_reset_mid();
        int waitc;
        @(negedge clk);
        for (int i = 0; i < 16; i++) blk[i] = abc_blk[511 - 32 * i -: 32];
        req_valid = 1'b1;
        req_last  = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_last  = 1'b0;
        waitc = 0;
        while (round_idx !== 6'd30 && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        checks++;
        if (round_idx !== 6'd30 || round_en !== 1'b1) begin
            errors++;
            $display("FAIL reach_r30 idx=%0d en=%b want 30 1", round_idx, round_en);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({req_ready, init_hash, load_block, round_en, final_add, hash_valid, busy} !== 7'b1000000
            || round_idx !== 6'd0 || kt !== 32'h0) begin
            errors++;
            $display("FAIL midreset_outputs got %b idx=%0d kt=%h want 1000000 0 0",
                     {req_ready, init_hash, load_block, round_en, final_add, hash_valid, busy},
                     round_idx, kt);
        end
        drive_block(abc_blk, 1'b1, 1'b1, abc_dig);
        check_digest();
        do_ack();
    endtask

    task automatic test_ack_and_req();
        drive_block(abc_blk, 1'b1, 1'b1, abc_dig);
        check_digest();
        @(negedge clk);
        hash_ack  = 1'b1;
        req_valid = 1'b1;
        req_last  = 1'b1;
        exp_q.push_back(abc_dig);
        @(negedge clk);
        hash_ack = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || load_block !== 1'b0 || hash_valid !== 1'b0) begin
            errors++;
            $display("FAIL ackreq_idle rdy=%b load=%b hv=%b want 1 0 0",
                     req_ready, load_block, hash_valid);
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_last  = 1'b0;
        checks++;
        if (load_block !== 1'b1 || init_hash !== 1'b1) begin
            errors++;
            $display("FAIL ackreq_load load=%b init=%b want 1 1", load_block, init_hash);
        end
        check_digest();
        do_ack();
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_last  = 1'b0;
        hash_ack  = 1'b0;
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        abc_blk = {32'h61626380, {14{32'h0}}, 32'h00000018};
        two_b1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        two_b2  = {{15{32'h0}}, 32'h000001c0};
        abc_dig = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
        two_dig = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

        test_reset();
        test_abc();
        test_two_block();
        test_backpressure();
        test_reset_mid();
        test_ack_and_req();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
